// File: rtl/fxp_alu_pkg.sv
// Shared constants for the multi-cycle fixed-point ALU: default widths,
// opcode encodings, FSM state encoding and saturation bounds.
package fxp_alu_pkg;

  localparam int unsigned INST_W_P    = 4;
  localparam int unsigned INT_W_P     = 6;
  localparam int unsigned FRAC_W_P    = 10;
  localparam int unsigned DATA_W_P    = INT_W_P + FRAC_W_P;
  localparam int unsigned ACC_GUARD_P = 4;
  localparam int unsigned ACC_W_P     = 2 * DATA_W_P + ACC_GUARD_P;

  localparam logic [INST_W_P-1:0] OP_ADD  = INST_W_P'(0);
  localparam logic [INST_W_P-1:0] OP_SUB  = INST_W_P'(1);
  localparam logic [INST_W_P-1:0] OP_MUL  = INST_W_P'(2);
  localparam logic [INST_W_P-1:0] OP_MAC  = INST_W_P'(3);
  localparam logic [INST_W_P-1:0] OP_XOR  = INST_W_P'(4);
  localparam logic [INST_W_P-1:0] OP_ARS  = INST_W_P'(5);
  localparam logic [INST_W_P-1:0] OP_LR   = INST_W_P'(6);
  localparam logic [INST_W_P-1:0] OP_CLZ  = INST_W_P'(7);
  localparam logic [INST_W_P-1:0] OP_ACLR = INST_W_P'(8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Two's-complement saturation bounds for results and the accumulator
  localparam logic [DATA_W_P-1:0] SAT_MAX = {1'b0, {(DATA_W_P-1){1'b1}}};
  localparam logic [DATA_W_P-1:0] SAT_MIN = {1'b1, {(DATA_W_P-1){1'b0}}};
  localparam logic [ACC_W_P-1:0]  ACC_MAX = {1'b0, {(ACC_W_P-1){1'b1}}};
  localparam logic [ACC_W_P-1:0]  ACC_MIN = {1'b1, {(ACC_W_P-1){1'b0}}};

endpackage

// File: rtl/fxp_seq_mul.sv
// Iterative signed shift-add multiplier, one multiplier bit per cycle.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_start latches
// i_a/i_b and begins; o_done pulses one cycle when o_prod holds the exact
// 2*DATA_W signed product (DATA_W cycles after i_start).
module fxp_seq_mul #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic                  o_done,
  output logic [2*DATA_W-1:0]   o_prod
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic              run_q,    run_d;
  logic              done_q,   done_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [PROD_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [PROD_W-1:0] prod_q,   prod_d;

  // The multiplier's sign bit carries weight -2^(DATA_W-1), so the last
  // partial product is subtracted instead of added.
  always_comb begin
    run_d    = run_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (i_start) begin
      run_d    = 1'b1;
      cnt_d    = '0;
      mcand_d  = {{DATA_W{i_a[DATA_W-1]}}, i_a};
      mplier_d = i_b;
      prod_d   = '0;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        prod_d = (cnt_q == LAST) ? (prod_q - mcand_q) : (prod_q + mcand_q);
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
        run_d  = 1'b0;
        done_d = 1'b1;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      run_q    <= run_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign o_done = done_q;
  assign o_prod = prod_q;

endmodule

// File: rtl/fxp_alu_mc.sv
// Multi-cycle signed Q(INT_W).(FRAC_W) ALU with a saturating accumulator.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_in_valid,
// i_inst, i_data_a, i_data_b request (taken only while o_busy is low);
// o_busy high while a request is in flight; o_out_valid one-cycle result
// strobe; o_data result, held until the next result.
module fxp_alu_mc
  import fxp_alu_pkg::*;
#(
  parameter int unsigned INST_W    = INST_W_P,
  parameter int unsigned INT_W     = INT_W_P,
  parameter int unsigned FRAC_W    = FRAC_W_P,
  parameter int unsigned DATA_W    = INT_W + FRAC_W,
  parameter int unsigned ACC_GUARD = ACC_GUARD_P
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_busy,
  input  logic [INST_W-1:0] i_inst,
  input  logic [DATA_W-1:0] i_data_a,
  input  logic [DATA_W-1:0] i_data_b,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_data
);

  localparam int unsigned ACC_W  = 2 * DATA_W + ACC_GUARD;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic [ACC_W:0] RND = (ACC_W+1)'(2 ** (FRAC_W - 1));

  state_e            state_q, state_d;
  logic [INST_W-1:0] op_q,    op_d;
  logic [DATA_W-1:0] a_q,     a_d;
  logic [DATA_W-1:0] b_q,     b_d;
  logic [DATA_W-1:0] res_q,   res_d;
  logic [ACC_W-1:0]  acc_q,   acc_d;
  logic              busy_q,  busy_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] data_q,  data_d;

  logic              mul_start_c;
  logic              mul_done;
  logic [PROD_W-1:0] mul_prod;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W:0]    mac_sum;
  logic [ACC_W-1:0]  mac_sat;
  logic [DATA_W-1:0] alu_res;

  fxp_seq_mul #(.DATA_W(DATA_W)) u_mul (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (mul_start_c),
    .i_a     (i_data_a),
    .i_b     (i_data_b),
    .o_done  (mul_done),
    .o_prod  (mul_prod)
  );

  // Round half up at the binary point, shift back to Q format, saturate
  function automatic logic [DATA_W-1:0] round_sat(input logic [ACC_W-1:0] x);
    logic [ACC_W:0]          xr;
    logic [ACC_W:0]          sh;
    logic [ACC_W-DATA_W+1:0] top;
    xr  = {x[ACC_W-1], x} + RND;
    sh  = $signed(xr) >>> FRAC_W;
    top = sh[ACC_W:DATA_W-1];
    if ((&top) || !(|top)) return sh[DATA_W-1:0];
    return sh[ACC_W] ? SAT_MIN : SAT_MAX;
  endfunction

  // Saturating add/sub: a sign-extended carry disagreeing with the MSB is overflow
  function automatic logic [DATA_W-1:0] sat_addsub(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y,
                                                   input logic              sub);
    logic [DATA_W:0] s;
    if (sub) s = {x[DATA_W-1], x} - {y[DATA_W-1], y};
    else     s = {x[DATA_W-1], x} + {y[DATA_W-1], y};
    if (s[DATA_W] != s[DATA_W-1]) return s[DATA_W] ? SAT_MIN : SAT_MAX;
    return s[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] clz(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] n;
    logic              found;
    n     = '0;
    found = 1'b0;
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      if (!found) begin
        if (x[i]) found = 1'b1;
        else      n = n + DATA_W'(1);
      end
    end
    return n;
  endfunction

  // Single-cycle operations on the latched operands
  always_comb begin
    logic [DATA_W-1:0] amt;
    amt     = b_q % DATA_W'(DATA_W);
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = sat_addsub(a_q, b_q, 1'b0);
      OP_SUB:  alu_res = sat_addsub(a_q, b_q, 1'b1);
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_ARS:  alu_res = $signed(a_q) >>> b_q;
      OP_LR:   alu_res = (a_q << amt) | (a_q >> (DATA_W'(DATA_W) - amt));
      OP_CLZ:  alu_res = clz(a_q);
      default: alu_res = '0;
    endcase
  end

  // Accumulator update with saturation at the full accumulator width
  always_comb begin
    prod_ext = {{(ACC_W-PROD_W){mul_prod[PROD_W-1]}}, mul_prod};
    mac_sum  = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
    if (mac_sum[ACC_W] != mac_sum[ACC_W-1]) mac_sat = mac_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    else                                    mac_sat = mac_sum[ACC_W-1:0];
  end

  // Request sequencing; busy drops on the edge that retires o_out_valid
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    acc_d       = acc_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    data_d      = data_q;
    mul_start_c = 1'b0;
    if (out_valid_q) busy_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_in_valid && !busy_q) begin
          op_d   = i_inst;
          a_d    = i_data_a;
          b_d    = i_data_b;
          busy_d = 1'b1;
          if (i_inst == OP_MUL || i_inst == OP_MAC) begin
            mul_start_c = 1'b1;
            state_d     = ST_MUL;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        res_d = alu_res;
        if (op_q == OP_ACLR) acc_d = '0;
        state_d = ST_DONE;
      end
      ST_MUL: begin
        if (mul_done) begin
          if (op_q == OP_MAC) begin
            acc_d = mac_sat;
            res_d = round_sat(mac_sat);
          end else begin
            res_d = round_sat(prod_ext);
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid_d = 1'b1;
        data_d      = res_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_out_valid = out_valid_q;
  assign o_data      = data_q;

endmodule

// File: doc/fxp_alu_mc.md
FXP_ALU_MC -- requirements
Module: fxp_alu_mc

Interface
REQ-001 SHALL have parameter INST_W, 4, opcode width.
REQ-002 SHALL have parameter INT_W, 6, integer bits of signed Q format.
REQ-003 SHALL have parameter FRAC_W, 10, fraction bits.
REQ-004 SHALL have parameter DATA_W, INT_W+FRAC_W, operand/result width.
REQ-005 SHALL have parameter ACC_GUARD, 4, accumulator guard bits; ACC_W = 2*DATA_W+ACC_GUARD.
REQ-006 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port i_in_valid  input  1  request strobe.
REQ-009 SHALL have port o_busy  output  1  high while a request is in flight.
REQ-010 SHALL have port i_inst  input  INST_W  opcode.
REQ-011 SHALL have ports i_data_a, i_data_b  input  DATA_W  signed Q(INT_W).(FRAC_W) operands.
REQ-012 SHALL have port o_out_valid  output  1  one-cycle result strobe.
REQ-013 SHALL have port o_data  output  DATA_W  result, held until next result.

Function
REQ-014 SHALL accept a request at edge E0 only when i_in_valid=1 and o_busy=0; i_in_valid with o_busy=1 is dropped with no side effect.
REQ-015 SHALL latch opcode and operands at E0; o_busy rises after E0 and falls after the edge that deasserts o_out_valid.
REQ-016 SHALL use FSM IDLE -> EXEC (single-cycle ops) or IDLE -> MUL (DATA_W iterations) -> DONE -> IDLE; EXEC -> DONE.
REQ-017 SHALL present single-cycle results with o_out_valid high for exactly the cycle after E0+2; MUL/MAC results after E0+DATA_W+2.
REQ-018 SHALL implement 0 ADD, 1 SUB: saturate to 0x7FF..F / 0x80..0 on signed overflow.
REQ-019 SHALL implement 2 MUL: exact signed a*b (2*DATA_W), add 2^(FRAC_W-1), arithmetic shift right FRAC_W, saturate to DATA_W.
REQ-020 SHALL implement 3 MAC: acc += exact a*b, acc saturating at ACC_W bounds; output = acc rounded/shifted/saturated per REQ-019.
REQ-021 SHALL implement 4 XOR bitwise; 5 ARS a>>>b, b unsigned, b>=DATA_W gives sign fill; 6 LR rotate-left a by b mod DATA_W.
REQ-022 SHALL implement 7 CLZ: leading-zero count of a as unsigned integer in o_data; a=0 gives DATA_W.
REQ-023 SHALL implement 8 ACLR: acc=0, o_data=0, single-cycle latency.
REQ-024 SHALL treat opcodes 9..2^INST_W-1 as single-cycle, o_data=0, o_out_valid still pulsed.
REQ-025 SHALL leave acc unchanged by every opcode except MAC and ACLR.

Reset
REQ-026 SHALL on i_rst_n=0, immediately and at any FSM state: o_busy=0, o_out_valid=0, o_data=0, acc=0, FSM=IDLE, iteration counter=0.
REQ-027 SHALL discard any in-flight request on reset; no o_out_valid follows reset release until a new accept.

Structure
REQ-028 SHALL place opcode constants, FSM state encoding, and saturation bound constants in shared package fxp_alu_pkg.
REQ-029 SHALL implement the iterative signed multiplier as sub-module fxp_seq_mul (start/done handshake, DATA_W-cycle shift-add, sign correction on final iteration).
REQ-030 SHALL keep rounding/saturation in the parent so MUL and MAC share it.

Verification
REQ-031 SHALL cover ADD 0x7C00+0x0800 -> 0x7FFF; SUB 0x8400-0x0800 -> 0x8000; out_valid after E0+2.
REQ-032 SHALL cover MUL 0x0600*0xFA00 -> 0xF700, out_valid after E0+18; MUL 0x0001*0x0200 -> 0x0001 (round half up).
REQ-033 SHALL cover ACLR, then MAC 0x0400*0x0400 twice -> 0x0400 then 0x0800; MAC 0x7FFF*0x7FFF -> 0x7FFF.
REQ-034 SHALL cover CLZ 0x0001 -> 0x000F, CLZ 0x0000 -> 0x0010; ARS 0x8000 by 3 -> 0xF000; LR 0x8001 by 1 -> 0x0003.
REQ-035 SHALL cover i_in_valid pulsed every cycle during MUL -> only first accepted, exactly one out_valid, acc/data unaffected by dropped requests.
REQ-036 SHALL cover i_rst_n asserted mid-MUL -> outputs 0 immediately, no out_valid after release, next ADD 0x0400+0x0400 -> 0x0800.
